// File: rtl/prefetch_fetch_unit_pkg.sv
// Shared fetch-unit definitions: NOP encoding and fetch-trap cause codes.
package prefetch_fetch_unit_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        TRAP_NONE     = 2'b00,
        TRAP_MISALIGN = 2'b01,
        TRAP_RANGE    = 2'b10
    } trap_cause_e;

endpackage

// File: rtl/prefetch_fetch_unit_queue.sv
// Circular instruction queue with push, pop, synchronous flush and occupancy count.
module prefetch_fetch_unit_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_push_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_head,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (PW+1)'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Pointer, count and storage update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/prefetch_fetch_unit.sv
// Prefetching fetch stage: fetch PC, sync-read imem, epoch-tagged response slot and queue.
// Optional macro FETCH_BYPASS_EN forwards a response straight to decode when the queue is empty.
module prefetch_fetch_unit #(
    parameter int              XLEN        = 32,
    parameter int              IMEM_WORDS  = 512,
    parameter int              FETCH_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter string           IMEM_INIT   = ""
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           halt,
    input  logic                           br_redirect,
    input  logic [XLEN-1:0]                br_target,
    input  logic                           csr_redirect,
    input  logic [XLEN-1:0]                csr_target,
    input  logic                           out_ready,
    output logic                           out_valid,
    output logic [31:0]                    out_instr,
    output logic [XLEN-1:0]                out_pc,
    output logic [XLEN-1:0]                out_pc_4,
    output logic                           out_trap,
    output logic [1:0]                     out_trap_cause,
    output logic [$clog2(FETCH_DEPTH):0]   fq_count
);

    import prefetch_fetch_unit_pkg::*;

    localparam int CW = $clog2(FETCH_DEPTH) + 1;
    localparam int AW = $clog2(IMEM_WORDS);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic            trap;
        trap_cause_e     cause;
    } fetch_entry_t;

    logic [31:0]     r_mem [IMEM_WORDS];
    logic [XLEN-1:0] r_fetch_pc;
    logic            r_epoch;
    logic            r_trap_lock;
    logic            r_inflight;
    logic            r_resp_epoch;
    fetch_entry_t    r_resp;

    fetch_entry_t    w_q_head;
    fetch_entry_t    w_head;
    logic [CW-1:0]   w_count;
    logic [CW:0]     w_occ;
    logic            w_full;
    logic            w_empty;
    logic            w_redirect;
    logic [XLEN-1:0] w_target;
    logic            w_misalign;
    logic            w_range;
    logic            w_issue;
    logic            w_resp_ok;
    logic            w_bypass;
    logic            w_head_valid;
    logic            w_push;
    logic            w_pop;

    assign w_redirect = br_redirect || csr_redirect;
    assign w_target   = br_redirect ? br_target : csr_target;
    assign w_misalign = (r_fetch_pc[1:0] != 2'b00);
    assign w_range    = ((r_fetch_pc >> 2) >= XLEN'(IMEM_WORDS));
    // The in-flight word already owns a queue slot, so count it against capacity.
    assign w_occ      = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
    assign w_issue    = !halt && !r_trap_lock && !w_redirect && (w_occ < (CW+1)'(FETCH_DEPTH));
    assign w_resp_ok  = r_inflight && (r_resp_epoch == r_epoch) && !w_redirect;

`ifdef FETCH_BYPASS_EN
    assign w_bypass = w_empty && w_resp_ok;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_head_valid = !w_empty || w_bypass;
    assign out_valid    = w_head_valid && !w_redirect;
    assign w_pop        = out_valid && out_ready && !w_empty;
    assign w_push       = w_resp_ok && !(w_bypass && out_ready);
    assign fq_count     = w_count;

    // Head selection: bypassed response or queue head.
    always_comb begin
        w_head = w_q_head;
        if (w_bypass) begin
            w_head = r_resp;
        end else begin
            w_head = w_q_head;
        end
    end

    // Decode-facing data, held at zero when nothing is presented.
    always_comb begin
        out_instr      = 32'h0000_0000;
        out_pc         = '0;
        out_pc_4       = '0;
        out_trap       = 1'b0;
        out_trap_cause = 2'b00;
        if (w_head_valid) begin
            out_instr      = w_head.instr;
            out_pc         = w_head.pc;
            out_pc_4       = w_head.pc + XLEN'(4);
            out_trap       = w_head.trap;
            out_trap_cause = w_head.cause;
        end else begin
            out_trap_cause = 2'b00;
        end
    end

    // Fetch PC, epoch, trap lock and the registered memory response slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fetch_pc   <= RESET_PC;
            r_epoch      <= 1'b0;
            r_trap_lock  <= 1'b0;
            r_inflight   <= 1'b0;
            r_resp_epoch <= 1'b0;
            r_resp.pc    <= '0;
            r_resp.instr <= 32'h0000_0000;
            r_resp.trap  <= 1'b0;
            r_resp.cause <= TRAP_NONE;
        end else if (w_redirect) begin
            r_fetch_pc  <= w_target;
            r_epoch     <= ~r_epoch;
            r_trap_lock <= 1'b0;
            r_inflight  <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_resp_epoch <= r_epoch;
                r_resp.pc    <= r_fetch_pc;
                if (w_misalign) begin
                    r_resp.instr <= NOP_INSTR;
                    r_resp.trap  <= 1'b1;
                    r_resp.cause <= TRAP_MISALIGN;
                    r_trap_lock  <= 1'b1;
                end else if (w_range) begin
                    r_resp.instr <= NOP_INSTR;
                    r_resp.trap  <= 1'b1;
                    r_resp.cause <= TRAP_RANGE;
                    r_trap_lock  <= 1'b1;
                end else begin
                    r_resp.instr <= r_mem[r_fetch_pc[AW+1:2]];
                    r_resp.trap  <= 1'b0;
                    r_resp.cause <= TRAP_NONE;
                    r_fetch_pc   <= r_fetch_pc + XLEN'(4);
                end
            end
        end
    end

    prefetch_fetch_unit_queue #(
        .DEPTH (FETCH_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_queue (
        .clk         (clk),
        .rst_n       (reset_n),
        .i_flush     (w_redirect),
        .i_push      (w_push),
        .i_push_data (r_resp),
        .i_pop       (w_pop),
        .o_head      (w_q_head),
        .o_count     (w_count),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

endmodule
